// File: rtl/teamd_serial_pkg.sv
// teamd serial receiver: shared state encoding
// and parity mode codes.
package teamd_serial_pkg;

   localparam logic [2:0] S_WAIT_IDLE = 3'd0;
   localparam logic [2:0] S_IDLE      = 3'd1;
   localparam logic [2:0] S_START     = 3'd2;
   localparam logic [2:0] S_DATA      = 3'd3;
   localparam logic [2:0] S_PARITY    = 3'd4;
   localparam logic [2:0] S_STOP      = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage

// File: rtl/teamd_bit_timer.sv
// teamd serial receiver: bit-period counter with
// mid-period and full-period ticks.
module teamd_bit_timer #(
   parameter int OVERSAMPLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic mid_tick,
   output logic full_tick
);

   localparam int CW  = $clog2(OVERSAMPLE) + 1;
   localparam int MID = OVERSAMPLE / 2;
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] MID_M1 =
      (MID > 0) ? CW'(MID - 1) : '0;

   logic [CW-1:0] cnt;

   // MID = 0 has no in-period tick; the owner skips START
   assign mid_tick  = (MID > 0) && (cnt == MID_M1);
   assign full_tick = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart || full_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/teamd_serial_rx.sv
// teamd serial receiver: synchroniser, frame FSM,
// LSB-first shifter, parity and framing checks.
module teamd_serial_rx
   import teamd_serial_pkg::*;
#(
   parameter int DATA_BITS   = 7,
   parameter int PARITY_MODE = 1,
   parameter int STOP_BITS   = 1,
   parameter int OVERSAMPLE  = 1
) (
   input  logic                 CLK,
   input  logic                 nReset,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity,
   output logic                 rx_load,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int MID = OVERSAMPLE / 2;
   localparam int IW  = $clog2(DATA_BITS + 4);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

   logic                 sync1;
   logic                 rx_s;
   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 fe;
   logic                 restart;
   logic                 mid_tick;
   logic                 full_tick;
   logic                 par_x;

   always_ff @(posedge CLK or negedge nReset) begin
      if (!nReset) begin
         sync1 <= 1'b0;
         rx_s  <= 1'b0;
      end else begin
         sync1 <= Rx;
         rx_s  <= sync1;
      end
   end

   assign restart = (state_nxt != state);

   teamd_bit_timer #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_timer (
      .clk      (CLK),
      .rst_n    (nReset),
      .restart  (restart),
      .mid_tick (mid_tick),
      .full_tick(full_tick)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
         // with MID = 0 the start is confirmed on detection
         S_IDLE: if (!rx_s)
            state_nxt = (MID == 0) ? S_DATA : S_START;
         S_START: if (mid_tick)
            state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA: if (full_tick && idx == LAST_DATA)
            state_nxt = (PARITY_MODE != PAR_NONE) ?
                        S_PARITY : S_STOP;
         S_PARITY: if (full_tick) state_nxt = S_STOP;
         S_STOP: if (full_tick && idx == LAST_STOP)
            state_nxt = S_DONE;
         S_DONE: state_nxt = fe ? S_WAIT_IDLE : S_IDLE;
         default: state_nxt = S_WAIT_IDLE;
      endcase
   end

   assign par_x = (^shreg) ^ par_bit;
   assign busy  = (state != S_WAIT_IDLE) &&
                  (state != S_IDLE);

   always_ff @(posedge CLK or negedge nReset) begin
      if (!nReset) begin
         state      <= S_WAIT_IDLE;
         idx        <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         fe         <= 1'b0;
         rx_data    <= '0;
         rx_parity  <= 1'b0;
         rx_load    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state   <= state_nxt;
         rx_load <= 1'b0;
         if (restart) begin
            idx <= '0;
         end else if (full_tick &&
                      (state == S_DATA || state == S_STOP)) begin
            idx <= idx + IW'(1);
         end
         if (state == S_IDLE && !rx_s) begin
            fe      <= 1'b0;
            par_bit <= 1'b0;
         end
         if (state == S_DATA && full_tick) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         end
         if (state == S_PARITY && full_tick) begin
            par_bit <= rx_s;
         end
         if (state == S_STOP && full_tick && !rx_s) begin
            fe <= 1'b1;
         end
         if (state == S_DONE) begin
            rx_load   <= 1'b1;
            rx_data   <= shreg;
            frame_err <= fe;
            rx_parity <= (PARITY_MODE != PAR_NONE) ?
                         par_bit : 1'b0;
            if (PARITY_MODE == PAR_EVEN) begin
               parity_err <= par_x;
            end else if (PARITY_MODE == PAR_ODD) begin
               parity_err <= ~par_x;
            end else begin
               parity_err <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_teamd_serial_rx.sv
// Bench for teamd_serial_rx: three configurations,
// table of frames plus glitch/reset/back-to-back sequences.
module tb_teamd_serial_rx;

   typedef struct {
      logic [8:0] data;
      logic       par;
      logic       perr;
      logic       ferr;
      int         cyc;
   } exp_t;

   typedef struct {
      int         d;
      logic [8:0] data;
      logic       pbit;
      logic [1:0] stops;
      logic       perr;
      logic       ferr;
   } vec_t;

   logic clk = 1'b0;
   logic nReset;
   logic rx_a, rx_b, rx_c;
   logic [6:0] a_data;
   logic [7:0] b_data;
   logic [6:0] c_data;
   logic a_par, a_load, a_perr, a_ferr, a_busy;
   logic b_par, b_load, b_perr, b_ferr, b_busy;
   logic c_par, c_load, c_perr, c_ferr, c_busy;

   int cyc = 0;
   int ntests = 0;
   int nfail = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   vec_t vecs[12];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   teamd_serial_rx u_a (
      .CLK(clk), .nReset(nReset), .Rx(rx_a),
      .rx_data(a_data), .rx_parity(a_par),
      .rx_load(a_load), .parity_err(a_perr),
      .frame_err(a_ferr), .busy(a_busy)
   );

   teamd_serial_rx #(
      .DATA_BITS(8), .PARITY_MODE(2),
      .STOP_BITS(1), .OVERSAMPLE(16)
   ) u_b (
      .CLK(clk), .nReset(nReset), .Rx(rx_b),
      .rx_data(b_data), .rx_parity(b_par),
      .rx_load(b_load), .parity_err(b_perr),
      .frame_err(b_ferr), .busy(b_busy)
   );

   teamd_serial_rx #(
      .DATA_BITS(7), .PARITY_MODE(0),
      .STOP_BITS(2), .OVERSAMPLE(1)
   ) u_c (
      .CLK(clk), .nReset(nReset), .Rx(rx_c),
      .rx_data(c_data), .rx_parity(c_par),
      .rx_load(c_load), .parity_err(c_perr),
      .frame_err(c_ferr), .busy(c_busy)
   );

   task automatic check1(input string name,
                         input logic [8:0] got,
                         input logic [8:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask

   task automatic chk_load(input int d, input logic [8:0] data,
                           input logic par, input logic perr,
                           input logic ferr);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (d)
         0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
         1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
         default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
      endcase
      ntests++;
      if (!have) begin
         nfail++;
         $display("FAIL load%0d unexpected rx_load at cycle %0d data %h",
                  d, cyc, data);
      end else begin
         if (e.cyc != cyc) begin
            nfail++;
            $display("FAIL load%0d_time got cycle %0d want %0d",
                     d, cyc, e.cyc);
         end
         ntests++;
         if (data !== e.data || par !== e.par ||
             perr !== e.perr || ferr !== e.ferr) begin
            nfail++;
            $display("FAIL load%0d_word got d=%h p=%b pe=%b fe=%b want d=%h p=%b pe=%b fe=%b",
                     d, data, par, perr, ferr,
                     e.data, e.par, e.perr, e.ferr);
         end
      end
   endtask

   always @(negedge clk) begin
      if (a_load === 1'b1) chk_load(0, {2'b00, a_data}, a_par, a_perr, a_ferr);
      if (b_load === 1'b1) chk_load(1, {1'b0, b_data}, b_par, b_perr, b_ferr);
      if (c_load === 1'b1) chk_load(2, {2'b00, c_data}, c_par, c_perr, c_ferr);
   end

   task automatic set_rx(input int d, input logic v);
      case (d)
         0: rx_a = v;
         1: rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   function automatic logic [8:0] get_data(input int d);
      case (d)
         0: return {2'b00, a_data};
         1: return {1'b0, b_data};
         default: return {2'b00, c_data};
      endcase
   endfunction

   // call on a negedge; expected load cycle follows from E0 = cyc+1
   task automatic drive_frame(input int d, input logic [8:0] data,
                              input logic pbit, input logic [1:0] stops,
                              input logic eperr, input logic eferr,
                              input bit push, input int gap,
                              input logic idle);
      int nd, pe, ns, os, mid, nb;
      logic [15:0] fr;
      exp_t e;
      case (d)
         0: begin nd = 7; pe = 1; ns = 1; os = 1; mid = 0; end
         1: begin nd = 8; pe = 1; ns = 1; os = 16; mid = 8; end
         default: begin nd = 7; pe = 0; ns = 2; os = 1; mid = 0; end
      endcase
      fr = '1;
      fr[0] = 1'b0;
      nb = 1;
      for (int i = 0; i < nd; i++) begin fr[nb] = data[i]; nb++; end
      if (pe != 0) begin fr[nb] = pbit; nb++; end
      for (int i = 0; i < ns; i++) begin fr[nb] = stops[i]; nb++; end
      if (push) begin
         e.data = (nd == 8) ? data : {2'b00, data[6:0]};
         e.par  = (pe != 0) ? pbit : 1'b0;
         e.perr = eperr;
         e.ferr = eferr;
         e.cyc  = cyc + 1 + 3 + mid + (nb - 1) * os;
         case (d)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
         endcase
      end
      for (int i = 0; i < nb; i++) begin
         set_rx(d, fr[i]);
         repeat (os) @(negedge clk);
      end
      set_rx(d, idle);
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while ((qa.size() + qb.size() + qc.size()) > 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      ntests++;
      if ((qa.size() + qb.size() + qc.size()) > 0) begin
         nfail++;
         $display("FAIL drain_timeout pending %0d/%0d/%0d want 0",
                  qa.size(), qb.size(), qc.size());
         qa.delete();
         qb.delete();
         qc.delete();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{0, 9'h055, 1'b0, 2'b01, 1'b0, 1'b0};
      vecs[1]  = '{0, 9'h055, 1'b1, 2'b01, 1'b1, 1'b0};
      vecs[2]  = '{0, 9'h000, 1'b0, 2'b01, 1'b0, 1'b0};
      vecs[3]  = '{0, 9'h07F, 1'b1, 2'b01, 1'b0, 1'b0};
      vecs[4]  = '{0, 9'h07F, 1'b0, 2'b01, 1'b1, 1'b0};
      vecs[5]  = '{0, 9'h02A, 1'b1, 2'b01, 1'b0, 1'b0};
      vecs[6]  = '{1, 9'h0A3, 1'b1, 2'b01, 1'b0, 1'b0};
      vecs[7]  = '{1, 9'h0A3, 1'b0, 2'b01, 1'b1, 1'b0};
      vecs[8]  = '{1, 9'h0FF, 1'b1, 2'b01, 1'b0, 1'b0};
      vecs[9]  = '{1, 9'h000, 1'b0, 2'b01, 1'b1, 1'b0};
      vecs[10] = '{2, 9'h012, 1'b0, 2'b11, 1'b0, 1'b0};
      vecs[11] = '{2, 9'h06D, 1'b0, 2'b01, 1'b0, 1'b1};

      nReset = 1'b0;
      rx_a = 1'b1;
      rx_b = 1'b1;
      rx_c = 1'b1;
      repeat (3) @(negedge clk);
      check1("rst_data", {2'b00, a_data}, 9'h000);
      check1("rst_parity", {8'h00, a_par}, 9'h000);
      check1("rst_load", {8'h00, a_load}, 9'h000);
      check1("rst_perr", {8'h00, a_perr}, 9'h000);
      check1("rst_ferr", {8'h00, a_ferr}, 9'h000);
      check1("rst_busy", {8'h00, a_busy}, 9'h000);
      nReset = 1'b1;
      repeat (5) @(negedge clk);

      // stop bit low, line held low: load with frame error, then no restart
      drive_frame(0, 9'h055, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 20, 1'b0);
      wait_drain(50);
      check1("ferr_hold", {8'h00, a_ferr}, 9'h001);
      check1("ferr_idle_busy", {8'h00, a_busy}, 9'h000);
      set_rx(0, 1'b1);
      repeat (5) @(negedge clk);

      foreach (vecs[i]) begin
         drive_frame(vecs[i].d, vecs[i].data, vecs[i].pbit,
                     vecs[i].stops, vecs[i].perr, vecs[i].ferr,
                     1'b1, 4, 1'b1);
         wait_drain(400);
         repeat (4) @(negedge clk);
         check1($sformatf("hold%0d", i), get_data(vecs[i].d),
                vecs[i].data);
      end

      // two-cycle glitch on the 16x receiver
      begin
         int n0;
         n0 = cyc;
         rx_b = 1'b0;
         repeat (2) @(negedge clk);
         rx_b = 1'b1;
         while (cyc < n0 + 10) @(negedge clk);
         check1("glitch_busy_hi", {8'h00, b_busy}, 9'h001);
         @(negedge clk);
         check1("glitch_busy_lo", {8'h00, b_busy}, 9'h000);
         repeat (40) @(negedge clk);
      end

      // back-to-back: 10-bit frames, one idle cycle for DONE
      drive_frame(2, 9'h012, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1, 1'b1);
      drive_frame(2, 9'h06D, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 4, 1'b1);
      wait_drain(50);
      check1("b2b_last", {2'b00, c_data}, 9'h06D);

      // reset during 4th data bit of 0x4B
      begin
         logic [6:0] w;
         w = 7'h4B;
         rx_a = 1'b0;
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            rx_a = w[k];
            @(negedge clk);
         end
         rx_a = w[3];
         nReset = 1'b0;
         #1;
         check1("mrst_data", {2'b00, a_data}, 9'h000);
         check1("mrst_parity", {8'h00, a_par}, 9'h000);
         check1("mrst_perr", {8'h00, a_perr}, 9'h000);
         check1("mrst_ferr", {8'h00, a_ferr}, 9'h000);
         check1("mrst_busy", {8'h00, a_busy}, 9'h000);
         @(negedge clk);
         @(negedge clk);
         rx_a = 1'b1;
         @(negedge clk);
         nReset = 1'b1;
         repeat (5) @(negedge clk);
      end
      drive_frame(0, 9'h033, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 4, 1'b1);
      wait_drain(50);
      check1("post_rst_data", {2'b00, a_data}, 9'h033);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
